// File: rtl/synch_pkg.sv
// Shared types for the synchronization event recorder.
// State encoding, event record layout and counter helpers.
package synch_pkg;

  localparam int COUNT_W     = 8;
  localparam int EVT_VALUE_W = 4;
  localparam int EVT_STAMP_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic [EVT_VALUE_W-1:0] value;
    logic [EVT_STAMP_W-1:0] stamp;
  } evt_t;

  function automatic logic [COUNT_W-1:0] sat_inc(
    input logic [COUNT_W-1:0] c
  );
    return (&c) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/synch_event_fifo.sv
// Small register FIFO; extra pointer bit separates full from empty.
// Head entry is read straight from the storage array.
module synch_event_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic          full,
  output logic          empty,
  output logic [DW-1:0] dout
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_pop;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) &&
                  (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop = pop && !empty;
  assign dout   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Caller only pushes when there is room or a pop frees a slot.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/synch_event_recorder.sv
// Detects changes on a watched value, timestamps them into a FIFO,
// and raises a sticky test_done after exit count or timeout plus drain.
module synch_event_recorder
  import synch_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int DEPTH      = 4,
  parameter int STAMP_W    = 16,
  parameter int EXIT_COUNT = 10,
  parameter int TIMEOUT    = 400
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [WIDTH-1:0]   watch_value,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [WIDTH-1:0]   evt_value,
  output logic [STAMP_W-1:0] evt_stamp,
  output logic [7:0]         evt_count,
  output logic               overflow,
  output logic               timed_out,
  output logic               test_done
);

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam int DW   = WIDTH + STAMP_W;

  state_t             state;
  state_t             state_nx;
  logic [WIDTH-1:0]   prev;
  logic [STAMP_W-1:0] stamp;
  logic [TO_W-1:0]    tcount;
  logic [COUNT_W-1:0] count;

  logic          change;
  logic          in_run;
  logic          full;
  logic          empty;
  logic          pop;
  logic          push_ok;
  logic          drop;
  logic          hit_exit;
  logic          hit_to;
  logic [DW-1:0] head;

  assign change   = (watch_value != prev);
  assign in_run   = (state == RUN);
  assign pop      = !empty && evt_ready;
  assign push_ok  = in_run && change && (!full || pop);
  assign drop     = in_run && change && full && !pop;
  assign hit_exit = push_ok &&
                    (count == COUNT_W'(EXIT_COUNT - 1));
  assign hit_to   = in_run &&
                    (tcount == TO_W'(TIMEOUT - 1));

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (enable) state_nx = RUN;
      RUN:   if (hit_exit || hit_to) state_nx = DRAIN;
      DRAIN: if (empty) state_nx = DONE;
      DONE:  state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      prev      <= '0;
      stamp     <= '0;
      tcount    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      timed_out <= 1'b0;
    end else begin
      state <= state_nx;
      prev  <= watch_value;
      stamp <= stamp + 1'b1;
      if (in_run)
        tcount <= tcount + 1'b1;
      if (push_ok)
        count <= sat_inc(count);
      if (drop)
        overflow <= 1'b1;
      if (hit_to)
        timed_out <= 1'b1;
    end
  end

  synch_event_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (push_ok),
    .pop   (pop),
    .din   ({watch_value, stamp}),
    .full  (full),
    .empty (empty),
    .dout  (head)
  );

  assign evt_valid = !empty;
  assign evt_value = head[DW-1:STAMP_W];
  assign evt_stamp = head[STAMP_W-1:0];
  assign evt_count = count;
  assign test_done = (state == DONE);

endmodule
